// File: rtl/diff_sweep_ctrl.sv
// Frame-difference sweep controller: loads two frames from a valid/ready stream,
// then sweeps every address so the comparator can write the difference frame.
module diff_sweep_ctrl #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned PIX_W  = 24,
    parameter int unsigned NPIX   = 307200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_data,
    input  logic              in_frame,
    input  logic [PIX_W-1:0]  q1,
    input  logic [PIX_W-1:0]  q2,
    output logic [ADDR_W-1:0] address,
    output logic              wren1,
    output logic [PIX_W-1:0]  data1,
    output logic              wren2,
    output logic [PIX_W-1:0]  data2,
    output logic              wren3,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   diff_count
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] sweep_addr, sweep_nxt;
    logic [ADDR_W-1:0] ptr1, ptr1_nxt;
    logic [ADDR_W-1:0] ptr2, ptr2_nxt;
    logic [ADDR_W:0]   diff_nxt;
    logic              done_nxt;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sweep_addr <= '0;
            ptr1       <= '0;
            ptr2       <= '0;
            diff_count <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            sweep_addr <= sweep_nxt;
            ptr1       <= ptr1_nxt;
            ptr2       <= ptr2_nxt;
            diff_count <= diff_nxt;
            done       <= done_nxt;
        end
    end

    // Next-state, memory bus and load handshake
    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep_addr;
        ptr1_nxt  = ptr1;
        ptr2_nxt  = ptr2;
        diff_nxt  = diff_count;
        in_ready  = 1'b0;
        address   = sweep_addr;
        wren1     = 1'b0;
        wren2     = 1'b0;
        wren3     = 1'b0;
        data1     = in_data;
        data2     = in_data;
        busy      = (state != IDLE);

        case (state)
            IDLE: begin
                in_ready = ~start;
                address  = in_frame ? ptr2 : ptr1;
                wren1    = in_valid & ~start & ~in_frame;
                wren2    = in_valid & ~start & in_frame;
                if (wren1) ptr1_nxt = (ptr1 == LAST) ? '0 : ptr1 + ADDR_W'(1);
                if (wren2) ptr2_nxt = (ptr2 == LAST) ? '0 : ptr2 + ADDR_W'(1);
                if (start) begin
                    diff_nxt  = '0;
                    sweep_nxt = '0;
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                wren3 = 1'b1;
                if (q1 != q2) diff_nxt = diff_count + (ADDR_W + 1)'(1);
                if (sweep_addr == LAST) begin
                    state_nxt = DONE;
                end else begin
                    sweep_nxt = sweep_addr + ADDR_W'(1);
                    state_nxt = READ;
                end
            end
            DONE: begin
                ptr1_nxt  = '0;
                ptr2_nxt  = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        done_nxt = (state_nxt == DONE);
    end

endmodule
